// File: rtl/speaker_serializer.sv
// I2S stereo serializer: divides clk into MCLK/SCK/LRCK and shifts out one sample pair per 512-cycle frame.
// Build option SPK_MUTE_ON_UNDERRUN_EN: mute the frame on underrun instead of repeating the last sample.
`timescale 1ns/1ps

module speaker_serializer #(
  parameter int BITS = 16  // only 16 is supported; slot/bit indexing below assumes it
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] audio_in_left,
  input  logic [BITS-1:0] audio_in_right,
  input  logic            sample_valid,
  output logic            sample_req,
  output logic            audio_mclk,
  output logic            audio_lrck,
  output logic            audio_sck,
  output logic            audio_sdin,
  output logic            underrun
);

  logic [8:0]      cnt;
  logic [BITS-1:0] hold_l, hold_r;
  logic            pending;
  logic [BITS-1:0] frame_l, frame_r;
  logic [BITS-1:0] frame_l_nxt, frame_r_nxt;
  logic            underrun_q, underrun_nxt;
  logic            sdin_q;

  logic            frame_end;
  logic            slot_end;
  logic [3:0]      bit_idx;
  logic            next_bit;

  assign frame_end = (cnt == 9'd511);
  assign slot_end  = (cnt[3:0] == 4'hF);

  // Bit for the slot about to start. The one-bit I2S delay means the channel of the
  // next slot equals the channel of the current half, and its bit index is ~cnt[7:4].
  // At frame_end this still reads the old frame_r, giving the previous right[0] in slot 0.
  assign bit_idx  = ~cnt[7:4];
  assign next_bit = cnt[8] ? frame_r[bit_idx] : frame_l[bit_idx];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    frame_l_nxt  = frame_l;
    frame_r_nxt  = frame_r;
    underrun_nxt = underrun_q;
    if (frame_end) begin
      if (sample_valid) begin
        frame_l_nxt  = audio_in_left;
        frame_r_nxt  = audio_in_right;
        underrun_nxt = 1'b0;
      end else if (pending) begin
        frame_l_nxt  = hold_l;
        frame_r_nxt  = hold_r;
        underrun_nxt = 1'b0;
      end else begin
        underrun_nxt = 1'b1;
`ifdef SPK_MUTE_ON_UNDERRUN_EN
        frame_l_nxt  = '0;
        frame_r_nxt  = '0;
`else
        frame_l_nxt  = frame_l;
        frame_r_nxt  = frame_r;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: holding/frame registers are reset because the first frame after reset must be silent.
      cnt        <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      pending    <= 1'b0;
      frame_l    <= '0;
      frame_r    <= '0;
      underrun_q <= 1'b1;  // nothing has been delivered for the frame that follows reset
      sdin_q     <= 1'b0;
    end else begin
      cnt <= cnt + 9'd1;

      if (sample_valid) begin
        hold_l <= audio_in_left;
        hold_r <= audio_in_right;
      end

      // A valid in the cnt=511 cycle bypasses holding, so pending stays clear.
      if (frame_end)         pending <= 1'b0;
      else if (sample_valid) pending <= 1'b1;

      frame_l    <= frame_l_nxt;
      frame_r    <= frame_r_nxt;
      underrun_q <= underrun_nxt;

      if (slot_end) sdin_q <= next_bit;
    end
  end

  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];
  assign audio_sdin = sdin_q;
  assign sample_req = ~rst & (cnt == 9'd0);
  assign underrun   = ~rst & underrun_q;

endmodule
